// File: rtl/sfu_ctrl.sv
// Sequencer for the SFU accumulate/ReLU stage: pops psum vectors from the upstream
// FIFO, drives the SFU acc/bypass controls and strobes results into psum SRAM.
//
// state  | meaning
// IDLE   | waiting for start_i
// WAIT   | W.S: holding until a full group of N vectors is queued upstream
// ACC    | W.S: N cycles of pop with acc high
// DRAIN  | W.S: SFU output register settles
// EMIT   | W.S: write the accumulated vector
// STREAM | O.S/bypass: pop and write together whenever data is present
// DONE   | one-cycle job-end pulse
module sfu_ctrl #(
  parameter int ADDR_BW = 11,
  parameter int CNT_BW  = 8,
  parameter int FCNT_BW = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic               cfg_ws_i,
  input  logic               cfg_bypass_i,
  input  logic [CNT_BW-1:0]  cfg_num_acc_i,
  input  logic [CNT_BW-1:0]  cfg_num_out_i,
  input  logic [ADDR_BW-1:0] cfg_base_i,
  input  logic [FCNT_BW-1:0] src_cnt_i,
  output logic               src_rd_o,
  output logic               acc_o,
  output logic               bypass_o,
  output logic               wr_en_o,
  output logic [ADDR_BW-1:0] wr_addr_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_ACC    = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_EMIT   = 3'd4;
  localparam logic [2:0] S_STREAM = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam int CW = (CNT_BW > FCNT_BW) ? CNT_BW : FCNT_BW;

  logic [2:0]         state_q, state_d;
  logic               bypass_q, bypass_d;
  logic [CNT_BW-1:0]  n_q, n_d;
  logic [CNT_BW-1:0]  acc_left_q, acc_left_d;
  logic [CNT_BW-1:0]  out_left_q, out_left_d;
  logic [ADDR_BW-1:0] addr_q, addr_d;

  logic [CW-1:0] src_ext, n_ext;
  logic          group_ready;
  logic          rd, acc, wr, done;

  assign src_ext     = CW'(src_cnt_i);
  assign n_ext       = CW'(n_q);
  assign group_ready = (src_ext >= n_ext);

  always_comb begin
    state_d    = state_q;
    bypass_d   = bypass_q;
    n_d        = n_q;
    acc_left_d = acc_left_q;
    out_left_d = out_left_q;
    addr_d     = addr_q;
    rd         = 1'b0;
    acc        = 1'b0;
    wr         = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          bypass_d   = cfg_bypass_i;
          n_d        = (cfg_num_acc_i == '0) ? CNT_BW'(1) : cfg_num_acc_i;
          out_left_d = cfg_num_out_i;
          addr_d     = cfg_base_i;
          if (cfg_num_out_i == '0)            state_d = S_DONE;
          else if (cfg_ws_i && !cfg_bypass_i) state_d = S_WAIT;
          else                                state_d = S_STREAM;
        end
      end
      S_WAIT: begin
        if (group_ready) begin
          state_d    = S_ACC;
          acc_left_d = n_q - CNT_BW'(1);
        end
      end
      S_ACC: begin
        rd  = 1'b1;
        acc = 1'b1;
        if (acc_left_q == '0) state_d = S_DRAIN;
        else                  acc_left_d = acc_left_q - CNT_BW'(1);
      end
      S_DRAIN: state_d = S_EMIT;
      S_EMIT: begin
        wr         = 1'b1;
        addr_d     = addr_q + ADDR_BW'(1);
        out_left_d = out_left_q - CNT_BW'(1);
        // Skipping WAIT when the next group is already queued keeps the period at N+2.
        if (out_left_q == CNT_BW'(1)) state_d = S_DONE;
        else if (group_ready) begin
          state_d    = S_ACC;
          acc_left_d = n_q - CNT_BW'(1);
        end else begin
          state_d = S_WAIT;
        end
      end
      S_STREAM: begin
        if (src_cnt_i != '0) begin
          rd         = 1'b1;
          wr         = 1'b1;
          addr_d     = addr_q + ADDR_BW'(1);
          out_left_d = out_left_q - CNT_BW'(1);
          if (out_left_q == CNT_BW'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      bypass_q   <= 1'b0;
      n_q        <= '0;
      acc_left_q <= '0;
      out_left_q <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      bypass_q   <= bypass_d;
      n_q        <= n_d;
      acc_left_q <= acc_left_d;
      out_left_q <= out_left_d;
      addr_q     <= addr_d;
    end
  end

  assign src_rd_o  = rd;
  assign acc_o     = acc;
  assign wr_en_o   = wr;
  assign done_o    = done;
  assign wr_addr_o = addr_q;
  assign busy_o    = (state_q != S_IDLE);
  assign bypass_o  = bypass_q && (state_q != S_IDLE);

endmodule

// File: tb/tb_sfu_ctrl.sv
// Directed bench for sfu_ctrl: table of jobs run against a behavioural FWFT FIFO count,
// plus hand-written reset-mid-ACC and exact acc-pattern sequences.
module tb_sfu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic        cfg_ws_i;
  logic        cfg_bypass_i;
  logic [7:0]  cfg_num_acc_i;
  logic [7:0]  cfg_num_out_i;
  logic [10:0] cfg_base_i;
  logic [5:0]  src_cnt_i;
  logic        src_rd_o, acc_o, bypass_o, wr_en_o, busy_o, done_o;
  logic [10:0] wr_addr_o;

  sfu_ctrl #(.ADDR_BW(11), .CNT_BW(8), .FCNT_BW(6)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .cfg_ws_i(cfg_ws_i),
    .cfg_bypass_i(cfg_bypass_i), .cfg_num_acc_i(cfg_num_acc_i),
    .cfg_num_out_i(cfg_num_out_i), .cfg_base_i(cfg_base_i), .src_cnt_i(src_cnt_i),
    .src_rd_o(src_rd_o), .acc_o(acc_o), .bypass_o(bypass_o), .wr_en_o(wr_en_o),
    .wr_addr_o(wr_addr_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ws; bit byp; int n; int m; int base; int preload; int drip;
    int hold; int late; bit restart;
    int exp_pops; int exp_wr; int exp_acc; int done_max;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  int r_pops, r_wr, r_acc, r_done, r_addr_err, r_lat_err, r_strm_err, r_byp_err;
  int r_inv_err, r_hold_pops, r_hold_acc, r_done_lat;
  logic [9:0] r_accpat;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive_cfg(input vec_t v);
    cfg_ws_i      = v.ws;
    cfg_bypass_i  = v.byp;
    cfg_num_acc_i = 8'(v.n);
    cfg_num_out_i = 8'(v.m);
    cfg_base_i    = 11'(v.base);
  endtask

  // Entered just after a rising edge; leaves just after a rising edge.
  task automatic run_job(input vec_t v);
    int fifo, supplied, pop_idx, wr_idx, gstart, patpos, neff;
    bit rd, wr;
    fifo = v.preload; supplied = v.preload;
    pop_idx = 0; wr_idx = 0; gstart = 0; patpos = 0;
    neff = (v.n == 0) ? 1 : v.n;
    r_pops = 0; r_wr = 0; r_acc = 0; r_done = 0; r_addr_err = 0; r_lat_err = 0;
    r_strm_err = 0; r_byp_err = 0; r_inv_err = 0; r_hold_pops = 0; r_hold_acc = 0;
    r_done_lat = -1; r_accpat = '0;
    drive_cfg(v);
    src_cnt_i = 6'(fifo);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      rd = src_rd_o; wr = wr_en_o;
      if (rd && src_cnt_i == 0) r_inv_err++;
      if (acc_o && wr) r_inv_err++;
      if (rd) begin
        if (pop_idx % neff == 0) gstart = k;
        pop_idx++; r_pops++;
        if (k < v.hold) r_hold_pops++;
      end
      if (acc_o) begin
        r_acc++;
        if (k < v.hold) r_hold_acc++;
      end
      if (pop_idx > 0 && patpos < 10) begin
        r_accpat = {r_accpat[8:0], acc_o};
        patpos++;
      end
      if (wr) begin
        if (int'(wr_addr_o) != ((v.base + wr_idx) % 2048)) r_addr_err++;
        if (v.ws && !v.byp && (k - gstart) != neff + 1) r_lat_err++;
        wr_idx++; r_wr++;
      end
      if ((v.byp || !v.ws) && rd != wr) r_strm_err++;
      if (busy_o && bypass_o != v.byp) r_byp_err++;
      if (!busy_o && bypass_o) r_byp_err++;
      if (done_o) begin
        r_done++;
        if (r_done_lat < 0) r_done_lat = k;
      end
      if (r_done_lat >= 0 && k >= r_done_lat + 3) break;
      @(posedge clk); #1;
      if (rd) fifo--;
      if (v.drip != 0 && supplied < v.exp_pops && (k % v.drip) == v.drip - 1) begin
        fifo++; supplied++;
      end
      if (v.hold != 0 && k == v.hold - 1) begin
        fifo += v.late; supplied += v.late;
      end
      src_cnt_i = 6'(fifo);
      start_i = v.restart && (k == 2);
      if (v.restart && k == 2) begin
        cfg_ws_i = 1'b0; cfg_num_out_i = 8'd7; cfg_base_i = 11'h300;
      end
    end
    start_i = 1'b0;
  endtask

  task automatic check_job(input vec_t v, input int idx);
    string p;
    p = $sformatf("job%0d_", idx);
    chk({p, "timeout"},   (r_done_lat < 0) ? 1 : 0, 0);
    chk({p, "pops"},      r_pops, v.exp_pops);
    chk({p, "writes"},    r_wr, v.exp_wr);
    chk({p, "acc_cyc"},   r_acc, v.exp_acc);
    chk({p, "done_cnt"},  r_done, 1);
    chk({p, "done_lat"},  (r_done_lat <= v.done_max) ? 1 : 0, 1);
    chk({p, "addr_err"},  r_addr_err, 0);
    chk({p, "lat_err"},   r_lat_err, 0);
    chk({p, "strm_err"},  r_strm_err, 0);
    chk({p, "byp_err"},   r_byp_err, 0);
    chk({p, "inv_err"},   r_inv_err, 0);
    chk({p, "hold_pops"}, r_hold_pops, 0);
    chk({p, "hold_acc"},  r_hold_acc, 0);
  endtask

  vec_t tbl[8];
  vec_t va;

  initial begin
    //         ws byp n  m  base   pre drip hold late rst pops wr acc dmax
    tbl[0] = '{1, 0, 3, 2, 'h10,  6,  0,  0,  0,  0,  6,  2,  6, 30};
    tbl[1] = '{1, 0, 4, 1, 'h40,  3,  0,  10, 1,  0,  4,  1,  4, 40};
    tbl[2] = '{0, 0, 3, 5, 'h7FE, 0,  3,  0,  0,  0,  5,  5,  0, 40};
    tbl[3] = '{1, 1, 3, 2, 'h20,  2,  0,  0,  0,  0,  2,  2,  0, 10};
    tbl[4] = '{1, 0, 3, 0, 'h55,  4,  0,  0,  0,  0,  0,  0,  0, 1};
    tbl[5] = '{1, 0, 0, 3, 'h5,   3,  0,  0,  0,  0,  3,  3,  3, 30};
    tbl[6] = '{1, 0, 2, 3, 'h100, 0,  2,  0,  0,  0,  6,  3,  6, 60};
    tbl[7] = '{1, 0, 3, 2, 'h10,  6,  0,  0,  0,  1,  6,  2,  6, 30};
    va = tbl[0];

    reset = 1'b0; start_i = 1'b0; src_cnt_i = '0;
    drive_cfg(va);
    #12;
    chk("rst_busy", busy_o, 0);
    chk("rst_addr", wr_addr_o, 0);
    chk("rst_strobes", {src_rd_o, acc_o, wr_en_o, done_o, bypass_o}, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_job(tbl[i]);
      check_job(tbl[i], i);
      if (i == 0) chk("accpat_job0", r_accpat, 10'b1110011100);
    end

    // Reset asserted mid-ACC must clear outputs without a clock edge.
    drive_cfg(va);
    src_cnt_i = 6'd6;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge clk);
        if (acc_o) seen = 1'b1;
      end
      chk("midacc_reached", seen, 1);
    end
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("arst_rd",   src_rd_o, 0);
    chk("arst_acc",  acc_o, 0);
    chk("arst_wr",   wr_en_o, 0);
    chk("arst_addr", wr_addr_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_misc", {done_o, bypass_o}, 0);
    @(posedge clk); #1;
    chk("arst_hold_busy", busy_o, 0);
    chk("arst_hold_rd", src_rd_o, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    run_job(va);
    check_job(va, 8);
    chk("accpat_after_rst", r_accpat, 10'b1110011100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
